// File: rtl/program_sequencer_if.sv
// Program-memory read port and core start/done pins of the instruction sequencer.
// The sequencer drives the master side; memory and core models sit on the slave side.
interface program_sequencer_if #(
  parameter int ADDR_W = 4
);
  logic [ADDR_W-1:0] mem_addr;
  logic [11:0]       mem_data;
  logic [11:0]       machine_code;
  logic              start;
  logic              done;

  // start is a level held for the whole instruction; done is sampled only while start is high,
  // and start falls on the cycle after done is seen (done on the first start cycle is legal).
  // mem_data returns the word addressed one cycle earlier.
  modport master (
    output mem_addr,
    output machine_code,
    output start,
    input  mem_data,
    input  done
  );

  modport slave (
    input  mem_addr,
    input  machine_code,
    input  start,
    output mem_data,
    output done
  );
endinterface

// File: rtl/program_sequencer.sv
// Feeds the core one 12-bit word at a time from synchronous program memory, interprets
// HALT/JUMP/NOP itself, and traps instructions that never return done.
module program_sequencer #(
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 31
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    run,
  input  logic                    single_step,
  input  logic                    step,
  program_sequencer_if.master     bus,
  output logic                    halted,
  output logic                    fault,
  output logic [7:0]              instr_count,
  output logic [2:0]              state
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_DECODE = 3'd2;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_PAUSE  = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd6;
  localparam logic [2:0] S_BOUND  = 3'd7;

  logic [ADDR_W-1:0] pc;
  logic [11:0]       mc_q;
  logic              start_q;
  logic [CNT_W-1:0]  tcnt;
  logic              step_q;
  logic              halt_armed;

  logic [2:0]        opcode;
  logic [2:0]        p1;
  logic [ADDR_W-1:0] target;
  logic [ADDR_W-1:0] pc_next;
  logic [7:0]        count_inc;
  logic              step_rise;

  assign opcode    = mc_q[11:9];
  assign p1        = mc_q[8:6];
  assign target    = ADDR_W'(mc_q[5:0]);
  assign pc_next   = pc + ADDR_W'(1);
  assign count_inc = (instr_count == 8'hFF) ? 8'hFF : instr_count + 8'd1;
  assign step_rise = step & ~step_q;

  assign bus.mem_addr     = pc;
  assign bus.machine_code = mc_q;
  assign bus.start        = start_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      pc          <= '0;
      mc_q        <= '0;
      start_q     <= 1'b0;
      tcnt        <= '0;
      step_q      <= 1'b0;
      halt_armed  <= 1'b0;
      halted      <= 1'b0;
      fault       <= 1'b0;
      instr_count <= '0;
    end else begin
      step_q <= step;
      case (state)
        S_IDLE: begin
          if (run) state <= S_FETCH;
        end
        S_FETCH: begin
          mc_q  <= bus.mem_data;
          state <= S_DECODE;
        end
        S_DECODE: begin
          if (opcode == 3'b111) begin
            if (p1 == 3'b111) begin
              halted     <= 1'b1;
              halt_armed <= 1'b0;
              state      <= S_HALT;
            end else begin
              pc          <= (p1 == 3'b000) ? target : pc_next;
              instr_count <= count_inc;
              state       <= S_BOUND;
            end
          end else begin
            start_q <= 1'b1;
            tcnt    <= '0;
            state   <= S_EXEC;
          end
        end
        S_EXEC: begin
          // done wins over the timeout when both land on the same cycle.
          if (bus.done) begin
            start_q     <= 1'b0;
            pc          <= pc_next;
            instr_count <= count_inc;
            state       <= S_BOUND;
          end else if (tcnt == CNT_W'(TIMEOUT - 1)) begin
            start_q <= 1'b0;
            fault   <= 1'b1;
            state   <= S_FAULT;
          end else begin
            tcnt <= tcnt + CNT_W'(1);
          end
        end
        S_BOUND: begin
          if (!run)             state <= S_IDLE;
          else if (single_step) state <= S_PAUSE;
          else                  state <= S_FETCH;
        end
        S_PAUSE: begin
          if (!run)           state <= S_IDLE;
          else if (step_rise) state <= S_FETCH;
        end
        S_HALT: begin
          // pc is cleared while run is low so word 0 is already read when run returns.
          if (!run) begin
            halt_armed <= 1'b1;
            pc         <= '0;
          end else if (halt_armed) begin
            halt_armed <= 1'b0;
            halted     <= 1'b0;
            state      <= S_FETCH;
          end
        end
        S_FAULT: begin
          state <= S_FAULT;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: memory and core models, start-pulse scoreboard,
// reset, HALT, JUMP loop, single-step, timeout, run-drop, wrap and async reset scenarios.
module tb_program_sequencer;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_FETCH  = 3'd1;
  localparam logic [2:0] S_EXEC   = 3'd3;
  localparam logic [2:0] S_PAUSE  = 3'd4;
  localparam logic [2:0] S_HALT   = 3'd5;
  localparam logic [2:0] S_FAULT  = 3'd6;

  logic       clock;
  logic       reset;
  logic       run;
  logic       single_step;
  logic       step;
  logic       halted;
  logic       fault;
  logic [7:0] instr_count;
  logic [2:0] state;

  program_sequencer_if #(.ADDR_W(4)) bus ();

  program_sequencer #(.ADDR_W(4), .TIMEOUT(31)) dut (
    .clock       (clock),
    .reset       (reset),
    .run         (run),
    .single_step (single_step),
    .step        (step),
    .bus         (bus),
    .halted      (halted),
    .fault       (fault),
    .instr_count (instr_count),
    .state       (state)
  );

  logic [11:0] mem [16];
  logic [11:0] exp_q [$];
  int          w_q [$];
  int          n_checks = 0;
  int          n_pass = 0;
  int          core_lat = 2;
  int          exec_cyc = 0;
  int          hi_len = 0;
  int          cur_w = 0;
  int          n_starts = 0;
  int          addr_bad = 0;
  int          n_changes = 0;
  int          base;
  logic        prev_start = 1'b0;
  logic        sb_en = 1'b1;
  logic        seq_en = 1'b0;
  logic        watch3 = 1'b0;
  logic        saw3 = 1'b0;
  logic [3:0]  last_addr = 4'd0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // synchronous program memory
  always @(posedge clock) bus.mem_data <= mem[bus.mem_addr];

  // core model: done rises on the core_lat-th cycle of start; core_lat 0 never answers
  always @(negedge clock) begin
    if (bus.start) begin
      exec_cyc = exec_cyc + 1;
      bus.done = (core_lat != 0) && (exec_cyc >= core_lat);
    end else begin
      exec_cyc = 0;
      bus.done = 1'b0;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // scoreboard: each start rise pops the expected word and pulse width
  always @(negedge clock) begin
    if (reset) begin
      prev_start = 1'b0;
      hi_len     = 0;
      cur_w      = 0;
    end else begin
      if (bus.start && !prev_start) begin
        n_starts++;
        hi_len = 1;
        cur_w  = 0;
        if (sb_en) begin
          check("start_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            check("machine_code", bus.machine_code, exp_q.pop_front());
            cur_w = w_q.pop_front();
          end
        end
      end else if (bus.start) begin
        hi_len++;
      end else if (prev_start && cur_w != 0) begin
        check("start_width", hi_len, cur_w);
      end
      prev_start = bus.start;
      if (watch3 && bus.mem_addr == 4'd3) saw3 = 1'b1;
      if (seq_en && bus.mem_addr != last_addr) begin
        n_changes++;
        if (bus.mem_addr != (last_addr ^ 4'd1)) addr_bad++;
        last_addr = bus.mem_addr;
      end
    end
  end

  task automatic step_clk(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, input string tag);
    for (int i = 0; i < budget && state != s; i++) step_clk(1);
    check(tag, state, s);
  endtask

  task automatic push(input logic [11:0] code, input int width);
    exp_q.push_back(code);
    w_q.push_back(width);
  endtask

  task automatic fill(input logic [11:0] v);
    for (int i = 0; i < 16; i++) mem[i] = v;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    run = 1'b0;
    single_step = 1'b0;
    step = 1'b0;
    step_clk(2);
    reset = 1'b0;
    step_clk(1);
  endtask

  initial begin
    reset = 1'b1;
    run = 1'b0;
    single_step = 1'b0;
    step = 1'b0;
    fill(12'h000);
    step_clk(2);
    check("rst_state", state, S_IDLE);
    check("rst_mem_addr", bus.mem_addr, 0);
    check("rst_machine_code", bus.machine_code, 0);
    check("rst_start", bus.start, 0);
    check("rst_halted", halted, 0);
    check("rst_fault", fault, 0);
    check("rst_count", instr_count, 0);
    reset = 1'b0;
    step_clk(3);
    check("idle_hold", state, S_IDLE);

    // two core instructions then HALT; start timing and no read past the HALT word
    fill(12'h012);
    mem[0] = 12'h012; mem[1] = 12'h2C5; mem[2] = 12'hFC0;
    core_lat = 2;
    watch3 = 1'b1;
    push(12'h012, 2); push(12'h2C5, 2);
    run = 1'b1;
    step_clk(2);  check("t1_pre_start", bus.start, 0);
    step_clk(1);  check("t1_start_rise", bus.start, 1);
    step_clk(2);  check("t1_start_fall", bus.start, 0);
    step_clk(2);  check("t1_gap", bus.start, 0);
    step_clk(1);  check("t1_second_rise", bus.start, 1);
    wait_state(S_HALT, 20, "t1_halt_state");
    check("t1_halted", halted, 1);
    check("t1_count", instr_count, 2);
    check("t1_halt_code", bus.machine_code, 12'hFC0);
    step_clk(5);
    check("t1_halt_sticky", state, S_HALT);
    run = 1'b0;
    step_clk(1);
    push(12'h012, 2); push(12'h2C5, 2);
    run = 1'b1;
    step_clk(1);
    check("t1_exit_halted", halted, 0);
    check("t1_exit_state", state, S_FETCH);
    check("t1_exit_addr", bus.mem_addr, 0);
    wait_state(S_HALT, 40, "t1_rehalt_state");
    check("t1_recount", instr_count, 4);
    check("t1_never_addr3", saw3, 0);
    watch3 = 1'b0;
    do_reset();

    // JUMP loop: address toggles 0,1,0,1 and the counter saturates
    fill(12'h012);
    mem[1] = 12'hE00;
    core_lat = 1;
    sb_en = 1'b0;
    last_addr = 4'd0;
    seq_en = 1'b1;
    run = 1'b1;
    for (int i = 0; i < 2000 && instr_count != 8'hFF; i++) step_clk(1);
    check("t2_count_sat", instr_count, 8'hFF);
    step_clk(40);
    check("t2_count_hold", instr_count, 8'hFF);
    seq_en = 1'b0;
    check("t2_addr_seq_bad", addr_bad, 0);
    check("t2_addr_toggled", n_changes > 100, 1);
    run = 1'b0;
    step_clk(10);
    sb_en = 1'b1;
    do_reset();

    // single step: one instruction per step edge, held or early edges do nothing
    fill(12'h012);
    mem[0] = 12'h012; mem[1] = 12'h2C5; mem[2] = 12'h0A1; mem[3] = 12'hFC0;
    core_lat = 3;
    single_step = 1'b1;
    push(12'h012, 3);
    run = 1'b1;
    wait_state(S_PAUSE, 20, "t3_pause1");
    check("t3_pause1_start", bus.start, 0);
    check("t3_pause1_count", instr_count, 1);
    check("t3_pause1_addr", bus.mem_addr, 1);
    push(12'h2C5, 3);
    step = 1'b1;
    step_clk(1);
    check("t3_step_fetch", state, S_FETCH);
    wait_state(S_PAUSE, 20, "t3_pause2");
    step_clk(10);
    check("t3_held_step_state", state, S_PAUSE);
    check("t3_held_step_count", instr_count, 2);
    step = 1'b0;
    step_clk(1);
    push(12'h0A1, 3);
    step = 1'b1;
    step_clk(1);
    step = 1'b0;
    step_clk(1);
    step = 1'b1;
    wait_state(S_PAUSE, 20, "t3_pause3");
    step_clk(5);
    check("t3_early_edge_ignored", state, S_PAUSE);
    check("t3_pause3_count", instr_count, 3);
    step = 1'b0;
    step_clk(1);
    step = 1'b1;
    wait_state(S_HALT, 20, "t3_halt_state");
    check("t3_halted", halted, 1);
    do_reset();

    // timeout: NOP then a core word that never completes
    fill(12'h012);
    mem[0] = 12'hE40;
    core_lat = 0;
    push(12'h012, 31);
    run = 1'b1;
    wait_state(S_FAULT, 60, "t4_fault_state");
    check("t4_fault", fault, 1);
    check("t4_start_low", bus.start, 0);
    check("t4_pc_frozen", bus.mem_addr, 1);
    check("t4_count", instr_count, 1);
    run = 1'b0;
    step_clk(3);
    run = 1'b1;
    step_clk(5);
    check("t4_fault_sticky", state, S_FAULT);
    check("t4_fault_still", fault, 1);
    do_reset();
    check("t4_reset_clears_fault", fault, 0);

    // run drops mid-EXEC: instruction completes, then IDLE at pc+1, then resume
    fill(12'h012);
    mem[0] = 12'h012; mem[1] = 12'h2C5; mem[2] = 12'hFC0;
    core_lat = 6;
    push(12'h012, 6);
    run = 1'b1;
    wait_state(S_EXEC, 10, "t5_exec");
    run = 1'b0;
    wait_state(S_IDLE, 20, "t5_idle");
    check("t5_start_low", bus.start, 0);
    check("t5_pc", bus.mem_addr, 1);
    check("t5_count", instr_count, 1);
    push(12'h2C5, 6);
    run = 1'b1;
    wait_state(S_HALT, 30, "t5_halt");
    check("t5_count_final", instr_count, 2);
    do_reset();

    // wrap 15 -> 0, then asynchronous reset in the middle of EXEC
    fill(12'hE40);
    mem[0] = 12'h0C3; mem[15] = 12'h1AB;
    core_lat = 2;
    push(12'h0C3, 2); push(12'h1AB, 2); push(12'h0C3, 2);
    base = n_starts;
    run = 1'b1;
    for (int i = 0; i < 300 && n_starts < base + 3; i++) step_clk(1);
    check("t6_third_start", n_starts, base + 3);
    check("t6_wrapped_addr", bus.mem_addr, 0);
    check("t6_count", instr_count, 16);
    check("t6_no_fault", fault, 0);
    check("t6_in_exec", bus.start, 1);
    #2 reset = 1'b1;
    #1;
    check("t6_rst_start", bus.start, 0);
    check("t6_rst_addr", bus.mem_addr, 0);
    check("t6_rst_count", instr_count, 0);
    check("t6_rst_state", state, S_IDLE);
    run = 1'b0;
    step_clk(1);
    reset = 1'b0;
    step_clk(1);

    check("sb_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
